// File: rtl/gpi_debounce_if.sv
// Signal bundle between the board-input debouncer and the register block that owns
// its enables, clears and event flags.
interface gpi_debounce_if #(
   parameter int unsigned Width = 20
);
   logic [Width-1:0] gp_raw_i;
   logic [Width-1:0] rise_en_i;
   logic [Width-1:0] fall_en_i;
   logic [Width-1:0] evt_clr_i;
   logic [Width-1:0] gp_o;
   logic [Width-1:0] rise_o;
   logic [Width-1:0] fall_o;
   logic [Width-1:0] evt_o;
   logic             irq_o;

   modport slave (
      input  gp_raw_i, rise_en_i, fall_en_i, evt_clr_i,
      output gp_o, rise_o, fall_o, evt_o, irq_o
   );

   modport master (
      output gp_raw_i, rise_en_i, fall_en_i, evt_clr_i,
      input  gp_o, rise_o, fall_o, evt_o, irq_o
   );
endinterface

// File: rtl/gpi_debounce.sv
// Per-channel synchroniser and debouncer for buttons/switches, with edge pulses and
// sticky, individually enabled and cleared event flags feeding one interrupt line.
module gpi_debounce #(
   parameter int unsigned      Width          = 20,
   parameter int unsigned      DebounceCycles = 50000,
   parameter logic [Width-1:0] ResetVal       = '0
) (
   input logic           clk_sys_i,
   input logic           rst_sys_ni,
   gpi_debounce_if.slave gpi
);

   localparam int unsigned     CntW    = $clog2(DebounceCycles) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   if (DebounceCycles < 32'd1 || DebounceCycles > 32'd16777215) begin : g_bad_cycles
      $error("gpi_debounce: DebounceCycles must lie in 1..2^24-1");
   end

   logic [Width-1:0] sync1;
   logic [Width-1:0] sync2;
   logic [Width-1:0] stable;
   logic [Width-1:0] differs;
   logic [Width-1:0] commit;
   logic [Width-1:0] rise_q;
   logic [Width-1:0] fall_q;
   logic [Width-1:0] evt_q;
   logic [Width-1:0] evt_set;
   logic [CntW-1:0]  cnt [Width];

   // Any sample agreeing with the accepted level throws away all progress.
   function automatic logic [CntW-1:0] cnt_step(input logic             diff,
                                                 input logic [CntW-1:0] c);
      if (!diff || c == CntLast) begin
         return '0;
      end
      return c + CntW'(1);
   endfunction

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         sync1 <= ResetVal;
         sync2 <= ResetVal;
      end else begin
         sync1 <= gpi.gp_raw_i;
         sync2 <= sync1;
      end
   end

   always_comb begin
      differs = '0;
      commit  = '0;
      for (int i = 0; i < Width; i++) begin
         differs[i] = sync2[i] ^ stable[i];
         commit[i]  = differs[i] && (cnt[i] == CntLast);
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         for (int i = 0; i < Width; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < Width; i++) begin
            cnt[i] <= cnt_step(differs[i], cnt[i]);
         end
      end
   end

   // Edge pulses are registered alongside the level so they line up with the
   // first cycle gp_o shows the new value.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         stable <= ResetVal;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         stable <= stable ^ commit;
         rise_q <= commit & sync2;
         fall_q <= commit & ~sync2;
      end
   end

   assign evt_set = (rise_q & gpi.rise_en_i) | (fall_q & gpi.fall_en_i);

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_set | (evt_q & ~gpi.evt_clr_i);
      end
   end

   assign gpi.gp_o   = stable;
   assign gpi.rise_o = rise_q;
   assign gpi.fall_o = fall_q;
   assign gpi.evt_o  = evt_q;
   assign gpi.irq_o  = |evt_q;

endmodule

// File: doc/gpi_debounce.md
GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 SHALL have parameter Width, default 20, number of input channels (4 buttons + 16 switches).
REQ-002 SHALL have parameter DebounceCycles, default 50000, stable cycles required before accepting a level; legal range 1..2^24-1, other values fail elaboration.
REQ-003 SHALL have parameter ResetVal, Width bits, default all-0, reset level of sync and debounced state.
REQ-004 SHALL have port clk_sys_i  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_sys_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port gp_raw_i  input  Width  raw asynchronous board inputs.
REQ-007 SHALL have port gp_o  output  Width  debounced level per channel.
REQ-008 SHALL have port rise_o  output  Width  one-cycle pulse, debounced 0->1.
REQ-009 SHALL have port fall_o  output  Width  one-cycle pulse, debounced 1->0.
REQ-010 SHALL have port rise_en_i  input  Width  per-channel enable, capture rise events.
REQ-011 SHALL have port fall_en_i  input  Width  per-channel enable, capture fall events.
REQ-012 SHALL have port evt_clr_i  input  Width  per-channel clear of sticky event flags.
REQ-013 SHALL have port evt_o  output  Width  sticky captured-event flags.
REQ-014 SHALL have port irq_o  output  1  OR of evt_o.

Function
REQ-015 Each channel SHALL pass through a 2-flop synchroniser (sync1, sync2); no logic between the flops.
REQ-016 Each channel SHALL hold a counter of width clog2(DebounceCycles)+1 and a stable register driving gp_o.
REQ-017 Per edge: sync2 == stable -> counter := 0; sync2 != stable and counter < DebounceCycles-1 -> counter += 1; sync2 != stable and counter == DebounceCycles-1 -> stable := sync2, counter := 0.
REQ-018 Latency: a level held on gp_raw_i SHALL appear on gp_o exactly DebounceCycles+2 rising edges after the first edge sampling it.
REQ-019 Bounce: any cycle where sync2 returns to stable SHALL zero the counter; no partial credit kept.
REQ-020 Counter SHALL never exceed DebounceCycles-1; no wrap-around.
REQ-021 rise_o[i] SHALL be high exactly in the first cycle gp_o[i] is 1 after being 0; fall_o[i] likewise for 1->0; never both.
REQ-022 evt_o[i] SHALL set at the next edge when (rise_o[i] & rise_en_i[i]) | (fall_o[i] & fall_en_i[i]).
REQ-023 evt_o[i] SHALL clear at the next edge when evt_clr_i[i] is high and no set condition exists.
REQ-024 Simultaneous set and clear on a channel: set SHALL win.
REQ-025 irq_o SHALL be combinational |evt_o, no extra latency.
REQ-026 Enable changes SHALL affect only future events; existing flags are kept.
REQ-027 Channels SHALL be fully independent; counters run in parallel.

Reset
REQ-028 Asserting rst_sys_ni low SHALL immediately set sync1, sync2, stable to ResetVal; counters, evt_o to 0; rise_o, fall_o, irq_o to 0.
REQ-029 Reset mid-count SHALL discard progress; after release the count restarts from 0.
REQ-030 Release with gp_raw_i == ResetVal SHALL produce no rise/fall pulse or event.

Verification (bench: Width=4, DebounceCycles=4, ResetVal=0)
REQ-031 gp_raw_i[0] 0->1 held -> gp_o[0]=1 on 6th edge after first sample; rise_o[0] high exactly 1 cycle.
REQ-032 gp_raw_i[1] toggles 1,0,1 in 3-cycle bursts then holds 1 -> no change on gp_o[1] until 6 edges after final settle; single rise pulse.
REQ-033 rise_en_i=4'b0001, fall_en_i=0, channel 0 rises then falls -> evt_o=4'b0001, irq_o=1 after rise; fall adds nothing; evt_clr_i[0] pulse -> evt_o=0, irq_o=0.
REQ-034 evt_clr_i[2] high in same cycle as enabled rise_o[2] -> evt_o[2]=1 afterwards.
REQ-035 Assert reset at count 2 of 4 during a 0->1 on channel 3, release with input still 1 -> gp_o[3]=0 at release, gp_o[3]=1 after 6 further edges.
REQ-036 All 4 inputs rise same cycle -> all gp_o bits and rise_o bits change in the same cycle.
